// File: rtl/avalon_ram_pkg.sv
// Shared types and constants for the wait-stated Avalon-MM word RAM.
// Holds the controller state encoding, the bad-read pattern and the byte-lane merge helper.
package avalon_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam logic [31:0] BAD_READ = 32'hDEADBEEF;
    localparam int          WAIT_MAX = 15;
    localparam int          CNT_BITS = 4;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/avalon_ws_ctrl.sv
// Transaction controller for avalon_ram_ws: FSM, wait-state counter, address capture
// and protocol/range violation detection.
module avalon_ws_ctrl
    import avalon_ram_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [31:0]          address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic                 load_en_i,
    output logic                 waitrequest_o,
    output logic                 do_read_o,
    output logic                 do_write_o,
    output logic                 err_set_o,
    output logic [ADDR_BITS-1:0] mem_idx_o,
    output logic                 addr_bad_o
);

    // Out-of-range wait counts are clamped so the counter can never run away.
    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 :
                              ((WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES);
    localparam logic [CNT_BITS-1:0] WAIT_LAST = CNT_BITS'(WAIT_EFF);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic                wr_q, wr_d;

    logic        req;
    logic [31:0] cur_addr;
    logic [31:0] offset;
    logic        cur_bad;

    assign req = read_i | write_i;

    // In IDLE the live address is decoded so a one-wait-state read can load readdata
    // on the very edge that captures the address.
    assign cur_addr = (state_q == IDLE) ? address_i : addr_q;
    assign offset   = cur_addr - BASE_ADDR;
    assign cur_bad  = (cur_addr < BASE_ADDR)
                   || ((offset >> (ADDR_BITS + 2)) != 32'd0)
                   || (cur_addr[1:0] != 2'b00);

    assign mem_idx_o  = offset[ADDR_BITS+1:2];
    assign addr_bad_o = cur_bad;

    // NOTE: every output of this block gets a default before the case statement; a path
    // that left one unassigned would infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        do_read_o     = 1'b0;
        do_write_o    = 1'b0;
        err_set_o     = read_i && write_i;
        waitrequest_o = req && (state_q != ACK) && !reset_i;

        case (state_q)
            IDLE: begin
                if (req && !load_en_i) begin
                    addr_d = address_i;
                    wr_d   = write_i;
                    cnt_d  = CNT_BITS'(1);
                    if (cur_bad) begin
                        err_set_o = 1'b1;
                    end
                    if (WAIT_EFF == 1) begin
                        state_d   = ACK;
                        do_read_o = !write_i;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!req) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    err_set_o = 1'b1;
                end else begin
                    if (address_i != addr_q) begin
                        err_set_o = 1'b1;
                    end
                    if (!load_en_i) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                        if (cnt_d == WAIT_LAST) begin
                            state_d   = ACK;
                            do_read_o = !wr_q;
                        end
                    end
                end
            end

            ACK: begin
                state_d    = IDLE;
                cnt_d      = '0;
                do_write_o = wr_q && !cur_bad;
                if (req && (address_i != addr_q)) begin
                    err_set_o = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would create ordering races.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: rtl/avalon_ram_ws.sv
// Avalon-MM slave word RAM with fixed wait states, byte-enable writes, a backdoor
// preload port and a sticky bus_error flag.
module avalon_ram_ws
    import avalon_ram_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          address,
    input  logic                 write,
    input  logic                 read,
    output logic                 waitrequest,
    input  logic [31:0]          writedata,
    input  logic [3:0]           byteenable,
    output logic [31:0]          readdata,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data,
    output logic                 bus_error
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [31:0] mem [DEPTH];

    logic                 do_read;
    logic                 do_write;
    logic                 err_set;
    logic [ADDR_BITS-1:0] mem_idx;
    logic                 addr_bad;

    logic [31:0] readdata_q, readdata_d;
    logic        bus_error_q, bus_error_d;

    avalon_ws_ctrl #(
        .ADDR_BITS   (ADDR_BITS),
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_ctrl (
        .clk_i         (clk),
        .reset_i       (reset),
        .address_i     (address),
        .read_i        (read),
        .write_i       (write),
        .load_en_i     (load_en),
        .waitrequest_o (waitrequest),
        .do_read_o     (do_read),
        .do_write_o    (do_write),
        .err_set_o     (err_set),
        .mem_idx_o     (mem_idx),
        .addr_bad_o    (addr_bad)
    );

    assign readdata_d  = addr_bad ? BAD_READ : mem[mem_idx];
    assign bus_error_d = bus_error_q | err_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            if (do_read) begin
                readdata_q <= readdata_d;
            end
            bus_error_q <= bus_error_d;
        end
    end

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
    // contents are defined only after a preload or a bus write.
    // The load is written last so it overrides a coincident bus write to the same word.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[mem_idx] <= merge_bytes(mem[mem_idx], writedata, byteenable);
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign readdata  = readdata_q;
    assign bus_error = bus_error_q;

endmodule

// File: doc/avalon_ram_ws.md
Name: avalon_ram_ws

Overview:
- Parametrised successor to the CPU test RAM: an Avalon-MM slave word memory with configurable depth, base address and fixed wait-state count.
- Supports byte-enable writes and a backdoor preload port for instruction/data images.
- Reports protocol and range violations through a sticky error flag.
- Sits opposite top_level_CPU in every testbench; also usable as on-chip RAM in synthesis experiments.

Parameters:
- ADDR_BITS, 10: word-index width; depth is 2**ADDR_BITS words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- WAIT_CYCLES, 2: waitrequest-high cycles per transaction; legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- address  in  32  Avalon byte address
- write  in  1  Avalon write request
- read  in  1  Avalon read request
- waitrequest  out  1  Avalon stall
- writedata  in  32  write data
- byteenable  in  4  byte lanes; bit i enables writedata[8i+7:8i]
- readdata  out  32  read data, valid in the completing cycle
- load_en  in  1  backdoor write strobe
- load_addr  in  ADDR_BITS  backdoor word index
- load_data  in  32  backdoor word
- bus_error  out  1  sticky violation flag

Behaviour:
- Reset: reset is asynchronous and active-high. It forces state IDLE, cnt=0, readdata=0, bus_error=0 and captured address=0.
  - waitrequest is combinational and reads 0 when no request is present.
  - Memory contents are not reset.
- waitrequest = (read|write) && state!=ACK.
- IDLE: on a request (and !load_en), capture address and go to WAIT with cnt=1.
  - If WAIT_CYCLES==1, go directly to ACK instead.
- WAIT: cnt increments each cycle while the request is held.
  - When cnt==WAIT_CYCLES, go to ACK.
  - The readdata register loads at that same edge.
- ACK: waitrequest=0 and the transaction completes. A write commits at this edge (lanes merged per byteenable). Next state is IDLE unconditionally.
- Latency: exactly WAIT_CYCLES cycles with waitrequest high, then one completion cycle. Back-to-back requests restart from IDLE.
- Word index = (address-BASE_ADDR)>>2.
- Out of range: address<BASE_ADDR, index>=2**ADDR_BITS, or address[1:0]!=0.
  - Timing is unchanged.
  - Writes are dropped.
  - readdata returns 32'hDEADBEEF.
  - bus_error is set.
- read && write together: treated as a write; bus_error is set.
- Request dropped during WAIT (read and write both 0): return to IDLE, cnt=0, bus_error set.
- Address differs from the captured value during WAIT or ACK: bus_error set; the captured address is still used.
- readdata holds its last value until the next read reaches ACK. Writes do not alter it.
- byteenable==0 on a write: legal; the write completes with no memory change.
- load_en: writes the full word mem[load_addr]=load_data at the rising edge.
  - While load_en=1 in IDLE/WAIT, cnt is frozen and waitrequest stays high.
  - A bus write in ACK coincident with load_en to the same word: load wins.
- Reset mid-transaction: abort; no write commits. If the request is still held after reset deasserts, counting restarts from cnt=0 in IDLE.
- bus_error is cleared only by reset.

Decomposition:
- Package avalon_ram_pkg holds:
  - state_t enum {IDLE, WAIT, ACK}
  - BAD_READ=32'hDEADBEEF
  - WAIT_MAX=15
  - a byte-merge function (old word, new word, byteenable -> merged word)
- Sub-module avalon_ws_ctrl holds the FSM, wait counter, address capture and violation detection. It outputs waitrequest, do_read, do_write and err_set.
- The top level holds the memory array, load port and readdata register.

Test Plan:
- WAIT_CYCLES=2, BASE=0: read @0x04 after load mem[1]=32'h24020069 -> waitrequest high for 2 cycles, low on the 3rd; readdata=32'h24020069; bus_error=0.
- Write 32'h12345678 BE=4'b0101 @0x08 over 32'hFFFFFFFF, then read -> 32'hFF34FF78.
- Read @0x1002 (misaligned) and @BASE+4*2**ADDR_BITS -> each reads 32'hDEADBEEF after WAIT_CYCLES stalls; bus_error=1 and stays 1.
- Hold read with load_en high for 3 cycles -> waitrequest high for 3+WAIT_CYCLES cycles; readdata shows the newly loaded word when the load hit the same index.
- Assert reset during the second WAIT cycle of a write of 32'hAAAAAAAA @0x10 -> waitrequest=0 during reset, memory unchanged; after release the held write completes after WAIT_CYCLES stalls.
- Sweep WAIT_CYCLES=1 and 15 with a CPU running li $v0,0x69 / sb / lbu / halt -> register_v0==32'h69 at negedge active; no timeout within 1000 cycles.
